seq_det_ctrl: RTL and testbench

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_ctrl_if.sv | 23 ++
 rtl/seq_det_ctrl.sv | 120 ++++++++++++
 tb/tb_seq_det_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_ctrl_if.sv
// Word-in / result-out handshake bundle for seq_det_ctrl.
// master = environment side, slave = controller side.
interface seq_det_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
);
   logic             word_valid;
   logic [WIDTH-1:0] word_data;
   logic             word_ready;
   logic             res_valid;
   logic [CW-1:0]    res_count;
   logic             res_ready;

   modport master (
      output word_valid, word_data, res_ready,
      input  word_ready, res_valid, res_count
   );

   modport slave (
      input  word_valid, word_data, res_ready,
      output word_ready, res_valid, res_count
   );
endinterface

// File: rtl/seq_det_ctrl.sv
// Serializes parallel words MSB-first into an external sequence detector and counts its hits per word.
// Optional macro SEQ_DET_CLR_BETWEEN_WORDS_EN: one-cycle detector clear (CLR state) before every word.
module seq_det_ctrl #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic           clk,
   input  logic           reset,
   seq_det_ctrl_if.slave  bus,
   output logic           det_in_bit,
   output logic           det_reset,
   input  logic           det_detected,
   output logic [15:0]    total_count,
   output logic           busy
);

   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
`ifdef SEQ_DET_CLR_BETWEEN_WORDS_EN
      CLR,
`endif
      SHIFT,
      DRAIN,
      DONE
   } state_t;

   state_t           state, state_n;
   logic [IW-1:0]    idx, idx_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [CW-1:0]    res_count, res_count_n;
   logic [15:0]      total_n;
   logic [16:0]      total_sum;
   logic [IW-1:0]    bit_sel;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         idx         <= '0;
         shreg       <= '0;
         res_count   <= '0;
         total_count <= '0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         shreg       <= shreg_n;
         res_count   <= res_count_n;
         total_count <= total_n;
      end
   end

   always_comb begin
      state_n     = state;
      idx_n       = idx;
      shreg_n     = shreg;
      res_count_n = res_count;
      total_n     = total_count;
      total_sum   = '0;

      case (state)
         IDLE: begin
            if (bus.word_valid) begin
               shreg_n     = bus.word_data;
               idx_n       = '0;
               res_count_n = '0;
`ifdef SEQ_DET_CLR_BETWEEN_WORDS_EN
               state_n     = CLR;
`else
               state_n     = SHIFT;
`endif
            end
         end
`ifdef SEQ_DET_CLR_BETWEEN_WORDS_EN
         CLR: state_n = SHIFT;
`endif
         SHIFT: begin
            // Detector is Moore: the flag seen at idx 0 belongs to earlier history.
            if (idx != '0 && det_detected)
               res_count_n = res_count + CW'(1);
            if (idx == LAST_IDX)
               state_n = DRAIN;
            else
               idx_n = idx + IW'(1);
         end
         DRAIN: begin
            res_count_n = res_count + CW'(det_detected);
            total_sum   = {1'b0, total_count} + 17'(res_count_n);
            total_n     = total_sum[16] ? 16'hFFFF : total_sum[15:0];
            state_n     = DONE;
         end
         DONE: begin
            if (bus.res_ready)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bit_sel        = LAST_IDX - idx;
   assign det_in_bit     = (state == SHIFT) ? shreg[bit_sel] : shreg[0];
   assign bus.word_ready = (state == IDLE);
   assign bus.res_valid  = (state == DONE);
   assign bus.res_count  = res_count;
   assign busy           = (state != IDLE);

`ifdef SEQ_DET_CLR_BETWEEN_WORDS_EN
   assign det_reset = reset & (state != CLR);
`else
   assign det_reset = reset;
`endif

   a_count_range: assert property (@(posedge clk) disable iff (!reset)
      int'(res_count) <= WIDTH);

   a_result_hold: assert property (@(posedge clk) disable iff (!reset)
      (bus.res_valid && !bus.res_ready) |=> (bus.res_valid && $stable(res_count)));

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl with a two-ones stub detector; a second wide instance
// runs concurrently to drive total_count into saturation.
module tb_seq_det_ctrl;

   localparam int W   = 8;
   localparam int CWL = $clog2(W + 1);
   localparam int SW  = 126;
   localparam int SCW = $clog2(SW + 1);
`ifdef SEQ_DET_CLR_BETWEEN_WORDS_EN
   localparam int CLR_EN = 1;
`else
   localparam int CLR_EN = 0;
`endif
   localparam int LAT  = W + 1 + CLR_EN;
   localparam int SLAT = SW + 1 + CLR_EN;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit sat_done = 1'b0;

   // ---------------- main instance ----------------
   logic        reset;
   logic        det_in_bit, det_reset, det_detected, det_prev;
   logic [15:0] total_count;
   logic        busy;

   seq_det_ctrl_if #(.WIDTH(W), .CW(CWL)) bus ();

   seq_det_ctrl #(.WIDTH(W), .CW(CWL)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus.slave),
      .det_in_bit   (det_in_bit),
      .det_reset    (det_reset),
      .det_detected (det_detected),
      .total_count  (total_count),
      .busy         (busy)
   );

   always_ff @(posedge clk or negedge det_reset) begin
      if (!det_reset) begin
         det_prev     <= 1'b0;
         det_detected <= 1'b0;
      end else begin
         det_prev     <= det_in_bit;
         det_detected <= det_prev & det_in_bit;
      end
   end

   // ---------------- saturation instance ----------------
   logic        s_reset;
   logic        s_det_in_bit, s_det_reset, s_det_detected, s_det_prev;
   logic [15:0] s_total_count;
   logic        s_busy;

   seq_det_ctrl_if #(.WIDTH(SW), .CW(SCW)) sbus ();

   seq_det_ctrl #(.WIDTH(SW), .CW(SCW)) sdut (
      .clk          (clk),
      .reset        (s_reset),
      .bus          (sbus.slave),
      .det_in_bit   (s_det_in_bit),
      .det_reset    (s_det_reset),
      .det_detected (s_det_detected),
      .total_count  (s_total_count),
      .busy         (s_busy)
   );

   always_ff @(posedge clk or negedge s_det_reset) begin
      if (!s_det_reset) begin
         s_det_prev     <= 1'b0;
         s_det_detected <= 1'b0;
      end else begin
         s_det_prev     <= s_det_in_bit;
         s_det_detected <= s_det_prev & s_det_in_bit;
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Offer one word with res_ready high; check latency, count and running total.
   task automatic run_word(input logic [W-1:0] d, input int exp_cnt, input int exp_tot);
      int n;
      @(negedge clk);
      check("word_ready_idle", bus.word_ready, 1);
      bus.word_valid = 1'b1;
      bus.word_data  = d;
      bus.res_ready  = 1'b1;
      @(posedge clk);
      #1;
      bus.word_valid = 1'b0;
      bus.word_data  = ~d;
      check("det_reset_after_accept", det_reset, (CLR_EN != 0) ? 0 : 1);
      n = 0;
      while (!bus.res_valid && n < LAT + 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("latency", n, LAT);
      check("res_count", bus.res_count, exp_cnt);
      check("total_count", total_count, exp_tot);
      @(posedge clk);
      #1;
      check("idle_after_result", busy, 0);
   endtask

   task automatic s_word(input int exp_cnt, input int exp_tot);
      int n;
      @(negedge clk);
      sbus.word_valid = 1'b1;
      sbus.word_data  = '1;
      @(posedge clk);
      #1;
      sbus.word_valid = 1'b0;
      n = 0;
      while (!sbus.res_valid && n < SLAT + 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("sat_res_count", sbus.res_count, exp_cnt);
      check("sat_total", s_total_count, exp_tot);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [W-1:0] data;
      int           cnt;
      int           tot;
   } vec_t;

   // ---------------- main test ----------------
   initial begin
      vec_t vecs[6];
      int   seen;
      int   guard;

`ifdef SEQ_DET_CLR_BETWEEN_WORDS_EN
      vecs[0] = '{8'hFF, 7, 7};
      vecs[1] = '{8'h55, 0, 7};
      vecs[2] = '{8'h01, 0, 7};
      vecs[3] = '{8'h80, 0, 7};
      vecs[4] = '{8'hC3, 2, 9};
      vecs[5] = '{8'hFF, 7, 16};
`else
      // History carries across words: a held trailing 1 pairs with a leading 1.
      vecs[0] = '{8'hFF, 7, 7};
      vecs[1] = '{8'h55, 0, 7};
      vecs[2] = '{8'h01, 0, 7};
      vecs[3] = '{8'h80, 1, 8};
      vecs[4] = '{8'hC3, 2, 10};
      vecs[5] = '{8'hFF, 8, 18};
`endif

      reset          = 1'b0;
      bus.word_valid = 1'b0;
      bus.word_data  = '0;
      bus.res_ready  = 1'b0;
      repeat (3) @(negedge clk);
      check("det_reset_in_reset", det_reset, 0);
      reset = 1'b1;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_word_ready", bus.word_ready, 1);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_res_count", bus.res_count, 0);
      check("rst_total", total_count, 0);
      check("rst_det_in_bit", det_in_bit, 0);
      check("rst_det_reset", det_reset, 1);

      for (int i = 0; i < 6; i++)
         run_word(vecs[i].data, vecs[i].cnt, vecs[i].tot);

      // Backpressure: result must hold and new words must be ignored.
      @(negedge clk);
      bus.word_valid = 1'b1;
      bus.word_data  = 8'h0F;
      bus.res_ready  = 1'b0;
      @(posedge clk);
      #1;
      bus.word_valid = 1'b0;
      guard = 0;
      while (!bus.res_valid && guard < LAT + 10) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("bp_latency", guard, LAT);
      bus.word_valid = 1'b1;
      bus.word_data  = 8'hFF;
      repeat (5) begin
         @(negedge clk);
         check("bp_res_valid", bus.res_valid, 1);
         check("bp_res_count", bus.res_count, 3);
         check("bp_word_ready", bus.word_ready, 0);
         check("bp_total", total_count, (CLR_EN != 0) ? 19 : 21);
      end
      @(negedge clk);
      bus.word_valid = 1'b0;
      bus.res_ready  = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_valid", bus.res_valid, 0);
      check("bp_release_ready", bus.word_ready, 1);
      check("bp_release_total", total_count, (CLR_EN != 0) ? 19 : 21);

      // Mid-word reset at SHIFT idx 4.
      @(negedge clk);
      bus.word_valid = 1'b1;
      bus.word_data  = 8'hFF;
      @(posedge clk);
      #1;
      bus.word_valid = 1'b0;
      repeat (4 + CLR_EN) @(posedge clk);
      @(negedge clk);
      check("mid_busy", busy, 1);
      check("mid_det_in_bit", det_in_bit, 1);
      reset = 1'b0;
      #1;
      check("mr_busy", busy, 0);
      check("mr_word_ready", bus.word_ready, 1);
      check("mr_res_valid", bus.res_valid, 0);
      check("mr_res_count", bus.res_count, 0);
      check("mr_total", total_count, 0);
      check("mr_det_in_bit", det_in_bit, 0);
      check("mr_det_reset", det_reset, 0);
      @(negedge clk);
      reset = 1'b1;
      seen = 0;
      repeat (LAT + 4) begin
         @(negedge clk);
         if (bus.res_valid) seen = 1;
      end
      check("mr_no_result", seen, 0);
      run_word(8'hFF, 7, 7);

      guard = 0;
      while (!sat_done && guard < 100000) begin
         @(posedge clk);
         guard++;
      end
      check("sat_finished", sat_done, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // ---------------- saturation test ----------------
   initial begin
      int exp_tot;
      int cnt;
      int after_sat;
      int k;

      s_reset         = 1'b0;
      sbus.word_valid = 1'b0;
      sbus.word_data  = '0;
      sbus.res_ready  = 1'b1;
      repeat (3) @(negedge clk);
      s_reset = 1'b1;

      exp_tot   = 0;
      after_sat = 0;
      k         = 0;
      while (after_sat < 2 && k < 700) begin
         cnt     = (k == 0 || CLR_EN != 0) ? SW - 1 : SW;
         exp_tot = (exp_tot + cnt > 65535) ? 65535 : exp_tot + cnt;
         s_word(cnt, exp_tot);
         if (exp_tot == 65535) after_sat++;
         k++;
      end
      check("sat_final", s_total_count, 16'hFFFF);
      sat_done = 1'b1;
   end

endmodule
